truth_sweep_ctrl: RTL and testbench

Sequential stimulus driver and result capture for the combinational F-function stage (F = A(CD + B) + BC', built on the 2x4 positive-output, positive-enable decoder). On a start request it drives all 16 ABCD combinations with E = 1, then all 16 with E = 0. It samples F for each vector and accumulates two 16-bit truth tables. It sits directly upstream of the function stage, and F feeds back into it. The completed tables are read by the display/check logic.

---
 rtl/truth_sweep_ctrl_if.sv | 28 ++
 rtl/truth_sweep_ctrl.sv | 144 ++++++++++++++
 tb/tb_truth_sweep_ctrl.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/truth_sweep_ctrl_if.sv
// Link between the sweep controller and its surroundings: the vector/enable drive into the
// F-function stage, F fed back, and the capture/result signals read by display/check logic.
interface truth_sweep_ctrl_if;
  logic        start;
  logic        f_in;
  logic        a;
  logic        b;
  logic        c;
  logic        d;
  logic        e;
  logic        busy;
  logic        done;
  logic        sample_valid;
  logic [4:0]  sample_idx;
  logic        sample_f;
  logic [15:0] tt_en1;
  logic [15:0] tt_en0;

  modport master (
    input  start, f_in,
    output a, b, c, d, e, busy, done, sample_valid, sample_idx, sample_f, tt_en1, tt_en0
  );

  modport slave (
    output start, f_in,
    input  a, b, c, d, e, busy, done, sample_valid, sample_idx, sample_f, tt_en1, tt_en0
  );
endinterface

// File: rtl/truth_sweep_ctrl.sv
// Drives all 32 {E, ABCD} vectors into the F-function stage, holding each for SETTLE+1 cycles,
// and captures F into two 16-bit truth tables (E = 1 pass first, then E = 0).
module truth_sweep_ctrl #(
  parameter int unsigned SETTLE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  truth_sweep_ctrl_if.master bus
);

  localparam logic [3:0] SettleCnt = 4'(SETTLE);

  typedef enum logic [1:0] {
    StIdle,
    StHold,
    StDone
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        phase_q, phase_d;
  logic [3:0]  hold_cnt_q, hold_cnt_d;
  logic        e_q, e_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        sample_valid_q, sample_valid_d;
  logic [4:0]  sample_idx_q, sample_idx_d;
  logic        sample_f_q, sample_f_d;
  logic [15:0] tt_en1_q, tt_en1_d;
  logic [15:0] tt_en0_q, tt_en0_d;

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    phase_d        = phase_q;
    hold_cnt_d     = hold_cnt_q;
    e_d            = e_q;
    busy_d         = busy_q;
    done_d         = 1'b0;
    sample_valid_d = 1'b0;
    sample_idx_d   = sample_idx_q;
    sample_f_d     = sample_f_q;
    tt_en1_d       = tt_en1_q;
    tt_en0_d       = tt_en0_q;

    unique case (state_q)
      StIdle: begin
        e_d    = 1'b0;
        busy_d = 1'b0;
        if (bus.start) begin
          state_d    = StHold;
          tt_en1_d   = '0;
          tt_en0_d   = '0;
          idx_d      = '0;
          phase_d    = 1'b0;
          e_d        = 1'b1;
          busy_d     = 1'b1;
          hold_cnt_d = SettleCnt;
        end
      end

      StHold: begin
        if (hold_cnt_q != '0) begin
          hold_cnt_d = hold_cnt_q - 4'd1;
        end else begin
          if (!phase_q) tt_en1_d[idx_q] = bus.f_in;
          else          tt_en0_d[idx_q] = bus.f_in;
          sample_valid_d = 1'b1;
          sample_idx_d   = {phase_q, idx_q};
          sample_f_d     = bus.f_in;
          hold_cnt_d     = SettleCnt;

          if (idx_q != 4'd15) begin
            idx_d = idx_q + 4'd1;
          end else if (!phase_q) begin
            idx_d   = '0;
            phase_d = 1'b1;
            e_d     = 1'b0;
          end else begin
            // idx is left at 0 here so a..d (driven straight from idx) read 0 outside HOLD.
            state_d = StDone;
            idx_d   = '0;
            phase_d = 1'b0;
            e_d     = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end

      StDone: begin
        state_d = StIdle;
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= StIdle;
      idx_q          <= '0;
      phase_q        <= 1'b0;
      hold_cnt_q     <= '0;
      e_q            <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      sample_valid_q <= 1'b0;
      sample_idx_q   <= '0;
      sample_f_q     <= 1'b0;
      tt_en1_q       <= '0;
      tt_en0_q       <= '0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      phase_q        <= phase_d;
      hold_cnt_q     <= hold_cnt_d;
      e_q            <= e_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      sample_valid_q <= sample_valid_d;
      sample_idx_q   <= sample_idx_d;
      sample_f_q     <= sample_f_d;
      tt_en1_q       <= tt_en1_d;
      tt_en0_q       <= tt_en0_d;
    end
  end

  assign bus.a            = idx_q[3];
  assign bus.b            = idx_q[2];
  assign bus.c            = idx_q[1];
  assign bus.d            = idx_q[0];
  assign bus.e            = e_q;
  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.sample_idx   = sample_idx_q;
  assign bus.sample_f     = sample_f_q;
  assign bus.tt_en1       = tt_en1_q;
  assign bus.tt_en0       = tt_en0_q;

endmodule

// File: tb/tb_truth_sweep_ctrl.sv
// Bench for truth_sweep_ctrl: two instances (SETTLE = 1 and 0), each fed by a lookup-table model
// of the function stage; captures are scoreboarded against the lookup table.
module tb_truth_sweep_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  truth_sweep_ctrl_if bus1 ();
  truth_sweep_ctrl_if bus0 ();

  truth_sweep_ctrl #(.SETTLE(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  truth_sweep_ctrl #(.SETTLE(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  // Function stage model: bit {~e, a, b, c, d} of the lookup table is F.
  logic [31:0] lut [2];
  logic        start_r [2];

  assign bus1.start = start_r[1];
  assign bus0.start = start_r[0];
  assign bus1.f_in  = lut[1][{~bus1.e, bus1.a, bus1.b, bus1.c, bus1.d}];
  assign bus0.f_in  = lut[0][{~bus0.e, bus0.a, bus0.b, bus0.c, bus0.d}];

  logic        busy_w [2];
  logic        done_w [2];
  logic        sv_w   [2];
  logic        sf_w   [2];
  logic        e_w    [2];
  logic [3:0]  vec_w  [2];
  logic [4:0]  sidx_w [2];
  logic [15:0] tt1_w  [2];
  logic [15:0] tt0_w  [2];

  assign busy_w[1] = bus1.busy;          assign busy_w[0] = bus0.busy;
  assign done_w[1] = bus1.done;          assign done_w[0] = bus0.done;
  assign sv_w[1]   = bus1.sample_valid;  assign sv_w[0]   = bus0.sample_valid;
  assign sf_w[1]   = bus1.sample_f;      assign sf_w[0]   = bus0.sample_f;
  assign e_w[1]    = bus1.e;             assign e_w[0]    = bus0.e;
  assign sidx_w[1] = bus1.sample_idx;    assign sidx_w[0] = bus0.sample_idx;
  assign tt1_w[1]  = bus1.tt_en1;        assign tt1_w[0]  = bus0.tt_en1;
  assign tt0_w[1]  = bus1.tt_en0;        assign tt0_w[0]  = bus0.tt_en0;
  assign vec_w[1]  = {bus1.a, bus1.b, bus1.c, bus1.d};
  assign vec_w[0]  = {bus0.a, bus0.b, bus0.c, bus0.d};

  typedef struct packed {
    logic [4:0] idx;
    logic       f;
  } samp_t;

  samp_t exp_q1 [$];
  samp_t exp_q0 [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input int k, input string name);
    chk($sformatf("%s_dut%0d", name, k),
        {busy_w[k], done_w[k], sv_w[k], vec_w[k], e_w[k], sidx_w[k], sf_w[k], tt1_w[k], tt0_w[k]},
        64'd0);
  endtask

  function automatic logic [31:0] spec_lut();
    logic [31:0] l;
    logic        a, b, c, d;
    l = '0;
    for (int i = 0; i < 16; i++) begin
      a = i[3]; b = i[2]; c = i[1]; d = i[0];
      l[i] = (a & ((c & d) | b)) | (b & ~c);
    end
    return l;
  endfunction

  // Monitor: every capture must match the next expected vector of that instance.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int k = 0; k < 2; k++) begin
        if (sv_w[k]) begin
          samp_t got;
          samp_t want;
          got = {sidx_w[k], sf_w[k]};
          if ((k == 1 && exp_q1.size() == 0) || (k == 0 && exp_q0.size() == 0)) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_sample_dut%0d: got idx %0d f %0b, required no sample",
                     k, got.idx, got.f);
          end else begin
            if (k == 1) want = exp_q1.pop_front();
            else        want = exp_q0.pop_front();
            chk($sformatf("sample_dut%0d_idx%0d", k, want.idx), 64'(got), 64'(want));
          end
        end
      end
    end
  end

  // One sweep on instance k. pre: start already high from a chained request. chain: raise start
  // in the DONE cycle and leave it high. reset_at: drop rst_n just before edge S + reset_at.
  task automatic run_sweep(input int k, input bit pokes, input int reset_at, input bit spec,
                           input bit chain, input bit pre);
    int p;
    int last;
    int n;
    p    = (k == 1) ? 2 : 1;
    last = 32 * p;
    if (!pre) begin
      @(negedge clk);
      start_r[k] = 1'b1;
    end
    @(posedge clk);
    for (int i = 0; i < 32; i++) begin
      if (k == 1) exp_q1.push_back({i[4:0], lut[k][i]});
      else        exp_q0.push_back({i[4:0], lut[k][i]});
    end
    for (int m = 0; m <= last + 1; m++) begin
      @(negedge clk);
      start_r[k] = (pokes && (m == 19 || m == 39)) || (chain && m >= last);
      if (reset_at > 0 && m == reset_at - 1) begin
        #1 rst_n = 1'b0;
        #1 chk_zero(k, $sformatf("midreset_m%0d", m));
        if (k == 1) exp_q1.delete();
        else        exp_q0.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (m < last) begin
        n = m / p;
        chk($sformatf("ctl_dut%0d_m%0d", k, m), {busy_w[k], done_w[k], e_w[k], vec_w[k]},
            {1'b1, 1'b0, (n < 16), 4'(n % 16)});
      end else if (m == last) begin
        chk($sformatf("done_dut%0d", k), {busy_w[k], done_w[k], e_w[k], vec_w[k]},
            {1'b0, 1'b1, 1'b0, 4'd0});
        chk($sformatf("tables_dut%0d", k), {tt1_w[k], tt0_w[k]}, {lut[k][15:0], lut[k][31:16]});
        if (spec) chk($sformatf("spec_tables_dut%0d", k), {tt1_w[k], tt0_w[k]},
                      {16'hF830, 16'h0000});
      end else begin
        chk($sformatf("idle_after_dut%0d", k), {busy_w[k], done_w[k], e_w[k], vec_w[k]}, 7'd0);
        chk($sformatf("tables_hold_dut%0d", k), {tt1_w[k], tt0_w[k]},
            {lut[k][15:0], lut[k][31:16]});
        chk($sformatf("queue_empty_dut%0d", k),
            (k == 1) ? exp_q1.size() : exp_q0.size(), 64'd0);
      end
    end
  endtask

  initial begin
    int k;
    int ra;
    start_r[0] = 1'b0;
    start_r[1] = 1'b0;
    lut[0] = spec_lut();
    lut[1] = spec_lut();

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk_zero(0, $sformatf("idle%0d", i));
      chk_zero(1, $sformatf("idle%0d", i));
    end

    run_sweep(1, 1'b1, 0, 1'b1, 1'b0, 1'b0);
    run_sweep(1, 1'b0, 30, 1'b0, 1'b0, 1'b0);
    run_sweep(1, 1'b0, 0, 1'b1, 1'b1, 1'b0);
    run_sweep(1, 1'b0, 0, 1'b1, 1'b0, 1'b1);
    run_sweep(0, 1'b1, 0, 1'b1, 1'b0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      k      = r % 2;
      lut[k] = $urandom;
      ra     = ($urandom_range(0, 3) == 0) ? int'($urandom_range(2, 32 * (k + 1))) : 0;
      run_sweep(k, 1'($urandom_range(0, 1)), ra, 1'b0, 1'b0, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
